// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: merges ALU and load-unit results into an
// in-order FIFO, drains one entry per cycle onto the register-file write port,
// and forwards still-pending results to the two read-port lookups.
module rf_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [4:0]                 lsu_rd,
    input  logic [31:0]                lsu_data,
    output logic                       rf_we,
    output logic [4:0]                 rf_rd,
    output logic [31:0]                rf_wdata,
    input  logic [4:0]                 rs1_addr,
    input  logic [4:0]                 rs2_addr,
    output logic                       fwd1_hit,
    output logic [31:0]                fwd1_data,
    output logic                       fwd2_hit,
    output logic [31:0]                fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int DATA_W = 32;

    logic [4:0]        rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rf_we_q;
    logic [4:0]        rf_rd_q;
    logic [DATA_W-1:0] rf_wdata_q;

    logic              alu_push, lsu_push, pop;
    logic [PTR_W-1:0]  lsu_slot;

    // Ready looks at the current occupancy only; a same-cycle pop is not
    // credited, which keeps the ready path short. The ALU is served first.
    assign alu_ready = (count_q <= CNT_W'(DEPTH-1));
    assign lsu_ready = (count_q <= CNT_W'(DEPTH-2)) |
                       ((count_q == CNT_W'(DEPTH-1)) & ~alu_valid);

    // Writes to x0 complete the handshake but never occupy a slot.
    assign alu_push = alu_valid & alu_ready & (alu_rd != 5'd0);
    assign lsu_push = lsu_valid & lsu_ready & (lsu_rd != 5'd0);
    assign pop      = (count_q != '0);
    // When both push, the LSU entry lands behind the ALU entry (younger).
    assign lsu_slot = alu_push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;

    // Next-state for pointers and occupancy; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(alu_push) + PTR_W'(lsu_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(alu_push) + CNT_W'(lsu_push) - CNT_W'(pop);
    end

    // FIFO storage; payload needs no reset because occupancy gates its use.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            rd_mem_q[wr_ptr_q]   <= alu_rd;
            data_mem_q[wr_ptr_q] <= alu_data;
        end
        if (lsu_push) begin
            rd_mem_q[lsu_slot]   <= lsu_rd;
            data_mem_q[lsu_slot] <= lsu_data;
        end
    end

    // Control state and the register-file output register; the output
    // address/data hold their last value when the queue is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rf_we_q  <= pop;
            if (pop) begin
                rf_rd_q    <= rd_mem_q[rd_ptr_q];
                rf_wdata_q <= data_mem_q[rd_ptr_q];
            end
        end
    end

    // Youngest pending write to addr: start from the output register, then
    // scan FIFO entries oldest to newest so later matches override earlier.
    function automatic logic [DATA_W:0] lookup(input logic [4:0] addr);
        logic [PTR_W-1:0]  idx;
        logic              hit;
        logic [DATA_W-1:0] data;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (addr != 5'd0) begin
            if (rf_we_q && (rf_rd_q == addr)) begin
                hit  = 1'b1;
                data = rf_wdata_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (rd_mem_q[idx] == addr)) begin
                    hit  = 1'b1;
                    data = data_mem_q[idx];
                end
            end
        end
        return {hit, data};
    endfunction

    // Combinational forwarding for both read ports.
    always_comb begin
        {fwd1_hit, fwd1_data} = lookup(rs1_addr);
        {fwd2_hit, fwd2_data} = lookup(rs2_addr);
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign count    = count_q;

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue with hand-computed expectations.
module tb_rf_writeback_queue;

    logic        clk;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    rf_writeback_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle, then drive the request inputs and let them settle.
    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        @(posedge clk);
        #1;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'h0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_rd", 32'(rf_rd), 32'd0);
        chk("rst_wdata", rf_wdata, 32'h0);
        chk("rst_fwd1", 32'(fwd1_hit), 32'd0);

        // Single ALU write: visible on the write port two cycles later.
        cyc(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0);
        chk("t1_alu_ready", 32'(alu_ready), 32'd1);
        chk("t1_count_c1", 32'(count), 32'd0);
        idle();
        chk("t1_count_c2", 32'(count), 32'd1);
        chk("t1_we_c2", 32'(rf_we), 32'd0);
        idle();
        chk("t1_we_c3", 32'(rf_we), 32'd1);
        chk("t1_rd_c3", 32'(rf_rd), 32'd5);
        chk("t1_wdata_c3", rf_wdata, 32'hA5A5A5A5);
        chk("t1_count_c3", 32'(count), 32'd0);
        idle();
        chk("t1_we_c4", 32'(rf_we), 32'd0);
        chk("t1_rd_hold", 32'(rf_rd), 32'd5);
        chk("t1_wdata_hold", rf_wdata, 32'hA5A5A5A5);

        // Simultaneous ALU and LSU: ALU entry drains first.
        cyc(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        chk("t2_alu_ready", 32'(alu_ready), 32'd1);
        chk("t2_lsu_ready", 32'(lsu_ready), 32'd1);
        idle();
        chk("t2_count", 32'(count), 32'd2);
        idle();
        chk("t2_we_a", 32'(rf_we), 32'd1);
        chk("t2_rd_a", 32'(rf_rd), 32'd3);
        chk("t2_wdata_a", rf_wdata, 32'h11);
        idle();
        chk("t2_rd_b", 32'(rf_rd), 32'd4);
        chk("t2_wdata_b", rf_wdata, 32'h22);
        idle();
        chk("t2_we_end", 32'(rf_we), 32'd0);

        // Fill with no drain gap; occupancy saturates at DEPTH-1 under
        // continuous drain, where the LSU is held off while the ALU is valid.
        cyc(1'b1, 5'd8, 32'h800, 1'b1, 5'd9, 32'h900);
        chk("t3_c0_count", 32'(count), 32'd0);
        cyc(1'b1, 5'd10, 32'hA00, 1'b1, 5'd11, 32'hB00);
        chk("t3_c1_count", 32'(count), 32'd2);
        chk("t3_c1_lsu_ready", 32'(lsu_ready), 32'd1);
        cyc(1'b1, 5'd12, 32'hC00, 1'b1, 5'd13, 32'hD00);
        chk("t3_c2_count", 32'(count), 32'd3);
        chk("t3_c2_alu_ready", 32'(alu_ready), 32'd1);
        chk("t3_c2_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("t3_c2_rd", 32'(rf_rd), 32'd8);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hD00);
        chk("t3_c3_count", 32'(count), 32'd3);
        chk("t3_c3_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("t3_c3_rd", 32'(rf_rd), 32'd9);
        idle();
        chk("t3_c4_count", 32'(count), 32'd3);
        chk("t3_c4_rd", 32'(rf_rd), 32'd10);
        idle();
        chk("t3_c5_count", 32'(count), 32'd2);
        chk("t3_c5_rd", 32'(rf_rd), 32'd11);
        idle();
        chk("t3_c6_count", 32'(count), 32'd1);
        chk("t3_c6_rd", 32'(rf_rd), 32'd12);
        chk("t3_c6_wdata", rf_wdata, 32'hC00);
        idle();
        chk("t3_c7_count", 32'(count), 32'd0);
        chk("t3_c7_rd", 32'(rf_rd), 32'd13);
        chk("t3_c7_wdata", rf_wdata, 32'hD00);
        idle();
        chk("t3_c8_we", 32'(rf_we), 32'd0);

        // Forwarding of two writes to the same register: youngest wins.
        rs1_addr = 5'd7;
        rs2_addr = 5'd0;
        cyc(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
        chk("t4_same_cycle_hit", 32'(fwd1_hit), 32'd0);
        idle();
        chk("t4_f1_hit", 32'(fwd1_hit), 32'd1);
        chk("t4_f1_data", fwd1_data, 32'h2);
        chk("t4_f1_hit2", 32'(fwd2_hit), 32'd0);
        chk("t4_f1_data2", fwd2_data, 32'h0);
        idle();
        chk("t4_f2_rd", rf_wdata, 32'h1);
        chk("t4_f2_data", fwd1_data, 32'h2);
        idle();
        chk("t4_f3_hit", 32'(fwd1_hit), 32'd1);
        chk("t4_f3_data", fwd1_data, 32'h2);
        chk("t4_f3_wdata", rf_wdata, 32'h2);
        idle();
        chk("t4_f4_hit", 32'(fwd1_hit), 32'd0);
        chk("t4_f4_data", fwd1_data, 32'h0);

        // Write to x0: handshake only.
        cyc(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0);
        chk("t5_alu_ready", 32'(alu_ready), 32'd1);
        idle();
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_we_a", 32'(rf_we), 32'd0);
        idle();
        chk("t5_we_b", 32'(rf_we), 32'd0);

        // Reset with a partly full queue discards everything.
        rs1_addr = 5'd22;
        cyc(1'b1, 5'd20, 32'h14, 1'b1, 5'd21, 32'h15);
        cyc(1'b1, 5'd22, 32'h16, 1'b1, 5'd23, 32'h17);
        idle();
        chk("t6_pre_count", 32'(count), 32'd3);
        chk("t6_pre_hit", 32'(fwd1_hit), 32'd1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_we", 32'(rf_we), 32'd0);
        chk("t6_rd", 32'(rf_rd), 32'd0);
        chk("t6_hit", 32'(fwd1_hit), 32'd0);
        idle();
        chk("t6_we_a", 32'(rf_we), 32'd0);
        chk("t6_count_a", 32'(count), 32'd0);
        idle();
        chk("t6_we_b", 32'(rf_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
